// File: rtl/reset_seq_pkg.sv
// Shared state/cause encodings, default parameters and a width helper for reset_sequencer.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        HOLD    = 2'd1,
        RUN     = 2'd2,
        SW_HOLD = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_HARD = 2'd0,
        CAUSE_SW   = 2'd1,
        CAUSE_WDOG = 2'd2
    } cause_e;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_HOLD_CYCLES = 16;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_WDOG_CYCLES = 1024;

    // Bits needed to hold 0..max_val, never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/reset_sync.sv
// Async-assert / sync-deassert release chain: released_o rises STAGES edges after reset_n_i rises.
module reset_sync
    import reset_seq_pkg::*;
#(
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic clk_i,
    input  logic reset_n_i,
    output logic released_o
);

    logic [STAGES-1:0] chain_q;

    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], 1'b1};
        end
    end

    assign released_o = chain_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Sequenced reset generator: hard-reset release, 4-phase software reset and saturating event count.
// Optional watchdog reset is built in when RESET_SEQUENCER_WDOG_EN is defined.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             sw_reset_req_i,
    output logic             sw_reset_ack_o,
    input  logic             wdog_kick_i,
    output logic             reset_n_o,
    output logic             busy_o,
    output logic             wdog_fired_o,
    output logic [CNT_W-1:0] rst_count_o
);

    localparam int HOLD_W = cnt_width(HOLD_CYCLES);

    state_e            state_q, state_d;
    cause_e            cause_q, cause_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ack_q, ack_d;
    logic              reset_n_q;
    logic              busy_q;
    logic              released;
    logic              sw_trigger;
    logic              hold_done;
    logic              wdog_fire;

    reset_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .released_o (released)
    );

    assign sw_trigger = (state_q == RUN) && sw_reset_req_i && !ack_q;
    assign hold_done  = (hold_q == HOLD_W'(HOLD_CYCLES - 1));

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        hold_d  = hold_q;
        count_d = count_q;
        ack_d   = ack_q && sw_reset_req_i;

        case (state_q)
            SYNC: begin
                // The edge that observes the release already counts as the first hold edge.
                if (released) begin
                    hold_d  = HOLD_W'(1);
                    state_d = (HOLD_CYCLES == 1) ? RUN : HOLD;
                end
            end
            HOLD: begin
                hold_d = hold_q + 1'b1;
                if (hold_done) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (sw_trigger || wdog_fire) begin
                    state_d = SW_HOLD;
                    hold_d  = '0;
                    cause_d = sw_trigger ? CAUSE_SW : CAUSE_WDOG;
                    count_d = (count_q == '1) ? count_q : count_q + 1'b1;
                end
            end
            SW_HOLD: begin
                hold_d = hold_q + 1'b1;
                if (hold_done) begin
                    state_d = RUN;
                    if (cause_q == CAUSE_SW) begin
                        ack_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = SYNC;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= SYNC;
            cause_q   <= CAUSE_HARD;
            hold_q    <= '0;
            count_q   <= '0;
            ack_q     <= 1'b0;
            reset_n_q <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            hold_q    <= hold_d;
            count_q   <= count_d;
            ack_q     <= ack_d;
            reset_n_q <= (state_d == RUN);
            busy_q    <= (state_d != RUN);
        end
    end

`ifdef RESET_SEQUENCER_WDOG_EN
    localparam int WDOG_W = cnt_width(WDOG_CYCLES - 1);

    logic [WDOG_W-1:0] wdog_q;
    logic              fired_q;

    // A software request on the same edge takes priority over expiry.
    assign wdog_fire = (state_q == RUN) && !sw_trigger && !wdog_kick_i &&
                       (wdog_q == WDOG_W'(WDOG_CYCLES - 1));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wdog_q  <= '0;
            fired_q <= 1'b0;
        end else begin
            if ((state_q != RUN) || (state_d != RUN) || wdog_kick_i) begin
                wdog_q <= '0;
            end else begin
                wdog_q <= wdog_q + 1'b1;
            end
            fired_q <= wdog_fire;
        end
    end

    assign wdog_fired_o = fired_q;
`else
    logic unused_wdog;

    assign unused_wdog  = ^{wdog_kick_i, 32'(WDOG_CYCLES)};
    assign wdog_fire    = 1'b0;
    assign wdog_fired_o = 1'b0;
`endif

    assign reset_n_o      = reset_n_q;
    assign busy_o         = busy_q;
    assign sw_reset_ack_o = ack_q;
    assign rst_count_o    = count_q;

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Generates the reset that the tiny_alu clock/reset bundle distributes to the DUT side. It drives the reset into the bundle rather than consuming it.
- Takes a raw asynchronous active-low reset. Outputs a reset that asserts asynchronously and deasserts synchronously, after a minimum hold time.
- Also supports a software-requested reset through a 4-phase req/ack handshake, and an optional watchdog reset.
- Sits at the top of the tiny_alu environment, between board/TB reset and every block clocked by clk_i.

Parameters:
- SYNC_STAGES, 2, number of flops in the deassertion synchronizer (legal range 2..4).
- HOLD_CYCLES, 16, clk_i cycles reset_n_o stays low after synchronization or after a soft-reset trigger (≥1).
- CNT_W, 8, width of the soft-reset event counter.
- WDOG_CYCLES, 1024, watchdog timeout in clk_i cycles; used only with the macro.

Ports:
- clk_i, in, 1, the single clock.
- reset_n_i, in, 1, raw reset; asynchronous, active-low.
- sw_reset_req_i, in, 1, software reset request; a level-held 4-phase request.
- sw_reset_ack_o, out, 1, acknowledge for sw_reset_req_i.
- wdog_kick_i, in, 1, watchdog service pulse.
- reset_n_o, out, 1, sequenced reset to downstream blocks; active-low.
- busy_o, out, 1, high whenever the state is not RUN.
- wdog_fired_o, out, 1, one-cycle pulse when the watchdog expires.
- rst_count_o, out, CNT_W, count of soft and watchdog resets since the last hard reset.

Behaviour:
- Hard reset (reset_n_i low), asynchronous and effective regardless of state:
  - Outputs: reset_n_o=0, busy_o=1, sw_reset_ack_o=0, wdog_fired_o=0, rst_count_o=0.
  - Internal: synchronizer chain=0, state=SYNC, hold counter=0, watchdog counter=0.
  - Applies mid-sequence too: the sequence aborts and restarts from SYNC.
- Cycle numbering: edge 1 is the first clk_i rising edge after reset_n_i rises.
- SYNC state: the chain shifts in 1 on each edge. Its last stage is 1 after edge SYNC_STAGES, and the next state is HOLD.
- HOLD state:
  - The hold counter increments once per edge.
  - On the edge where it reaches HOLD_CYCLES, state=RUN and reset_n_o is registered to 1.
  - Total hard-reset release latency = SYNC_STAGES+HOLD_CYCLES edges (18 with defaults).
- RUN state: reset_n_o=1 and busy_o=0.
  - sw_reset_req_i sampled 1 while sw_reset_ack_o=0 → next state SW_HOLD, reset_n_o=0 after the same edge, hold counter cleared, rst_count_o+1.
- SW_HOLD state:
  - Counts HOLD_CYCLES edges, then moves to RUN.
  - reset_n_o=1 and sw_reset_ack_o=1 are registered on that same edge.
- 4-phase handshake:
  - sw_reset_ack_o stays 1 until sw_reset_req_i is sampled 0; ack falls on the following edge.
  - A request still held high while ack=1 never re-triggers.
- Requests outside RUN (during SYNC, HOLD, SW_HOLD) are not lost. They remain pending as a level and are acted on at the first RUN edge.
- rst_count_o saturates at 2^CNT_W-1 and does not wrap. Hard reset clears it; the hard-reset sequence itself is not counted.
- Outputs reset_n_o, busy_o, sw_reset_ack_o and wdog_fired_o are all registered, so no combinational path runs from inputs to outputs.
- busy_o is registered equal to (next_state != RUN).

Optional Feature:
- Macro: RESET_SEQUENCER_WDOG_EN.
- Defined:
  - The watchdog counter runs only in RUN, clears on wdog_kick_i, and clears on leaving RUN.
  - When it reaches WDOG_CYCLES-1 with no kick, the next edge enters SW_HOLD and drives reset_n_o=0, wdog_fired_o=1 for one cycle, and rst_count_o+1. No ack is generated.
  - If a sw request and watchdog expiry occur on the same edge, the sw request wins: ack is produced later and wdog_fired_o stays 0.
- Undefined: the watchdog logic is absent, wdog_kick_i is ignored, and wdog_fired_o is tied to 0. Ports are identical in both builds.

Decomposition:
- Package reset_seq_pkg:
  - state_e enum {SYNC, HOLD, RUN, SW_HOLD}.
  - Cause enum {CAUSE_HARD, CAUSE_SW, CAUSE_WDOG}.
  - Default parameter constants.
- Sub-module reset_sync: the SYNC_STAGES-deep async-assert/sync-deassert flop chain, outputting a synchronized release flag.

Test Plan:
1. Hard release: reset_n_i 0→1 with defaults → reset_n_o rises exactly after edge 18, and busy_o falls on the same edge.
2. Mid-sequence hard reset: pulse reset_n_i low at edge 10 → reset_n_o stays 0, and release occurs 18 edges after the second rise.
3. Soft reset in RUN: assert sw_reset_req_i at edge n → reset_n_o=0 after edge n, ack=1 and reset_n_o=1 after edge n+16, ack=0 one edge after req drops, rst_count_o=1.
4. Early or held request: req high during HOLD → acted on at the first RUN edge. Req kept high after ack → no second reset, and the count is unchanged.
5. Counter saturation with CNT_W=2: perform 5 soft resets → rst_count_o reads 1, 2, 3, 3, 3.
6. Watchdog (macro defined, WDOG_CYCLES=32):
   - Kicks every 20 cycles → no fire.
   - Stop kicking → wdog_fired_o pulses after 32 cycles and reset_n_o is low for 16 cycles.
   - Same-edge sw request → ack is produced and wdog_fired_o stays 0.
